// File: rtl/acia_sequencer.sv
// ACIA bus sequencer: master reset and configuration, periodic status polling,
// rx byte delivery and round-robin arbitration between two tx requesters.
module acia_sequencer #(
  parameter logic [7:0]  CR_VALUE = 8'h96,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reinit,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       init_done,
  output logic       acia_e,
  output logic       acia_sel,
  output logic       acia_rs,
  output logic       acia_rw,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  input  logic       acia_irq
);

  typedef enum logic [2:0] {
    MRST = 3'd0, CFG = 3'd1, GAP = 3'd2, POLL = 3'd3, RXRD = 3'd4, TXWR = 3'd5
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t     state_r, state_n_s;
  logic [1:0] phase_r, phase_n_s;
  logic [7:0] gap_r, gap_n_s;
  logic       started_r;
  logic       pend_r, pend_s;
  logic       ptr_r, ptr_n_s;
  logic [7:0] tx_byte_r, tx_byte_n_s;
  logic       grant1_s;
  logic       rdrf_r, tdre_r, err_r;
  logic       start_mrst_s;
  logic       sel_n_s, e_n_s, rs_n_s, rw_n_s;
  logic [7:0] din_n_s;
  logic       unused_s;

  assign unused_s = acia_irq;
  assign pend_s   = reinit | pend_r;
  // The pointed requester wins when valid, otherwise the other one is taken.
  assign grant1_s = ptr_r ? req1_valid : ~req0_valid;
  assign start_mrst_s = started_r && (state_n_s == MRST) && (phase_n_s == 2'd0) &&
                        ((state_r == GAP) || (phase_r == 2'd3));

  // Phase stepping, gap counting and post-poll decisions.
  always_comb begin
    state_n_s   = state_r;
    phase_n_s   = phase_r;
    gap_n_s     = gap_r;
    ptr_n_s     = ptr_r;
    tx_byte_n_s = tx_byte_r;
    if (!started_r) begin
      state_n_s = MRST;
      phase_n_s = 2'd0;
    end else if (state_r == GAP) begin
      if (pend_s) begin
        state_n_s = MRST;
        gap_n_s   = 8'd0;
      end else if (gap_r == GAP_LAST) begin
        state_n_s = POLL;
        gap_n_s   = 8'd0;
      end else begin
        gap_n_s = gap_r + 8'd1;
      end
    end else if (phase_r != 2'd3) begin
      phase_n_s = phase_r + 2'd1;
    end else begin
      phase_n_s = 2'd0;
      gap_n_s   = 8'd0;
      if (pend_s) begin
        state_n_s = MRST;
      end else begin
        case (state_r)
          MRST: state_n_s = CFG;
          POLL: begin
            if (rdrf_r) begin
              state_n_s = RXRD;
            end else if (tdre_r && (req0_valid || req1_valid)) begin
              state_n_s   = TXWR;
              ptr_n_s     = ~grant1_s;
              tx_byte_n_s = grant1_s ? req1_data : req0_data;
            end else begin
              state_n_s = GAP;
            end
          end
          default: state_n_s = GAP;
        endcase
      end
    end
  end

  // Bus pin values for the upcoming cycle; A3 drops sel but keeps rs/rw/din.
  always_comb begin
    sel_n_s = 1'b0;
    e_n_s   = 1'b0;
    rs_n_s  = 1'b0;
    rw_n_s  = 1'b1;
    din_n_s = 8'h00;
    if (state_n_s != GAP) begin
      sel_n_s = (phase_n_s != 2'd3);
      e_n_s   = (phase_n_s == 2'd1) || (phase_n_s == 2'd2);
      case (state_n_s)
        MRST: begin rs_n_s = 1'b0; rw_n_s = 1'b0; din_n_s = 8'h03;       end
        CFG:  begin rs_n_s = 1'b0; rw_n_s = 1'b0; din_n_s = CR_VALUE;    end
        POLL: begin rs_n_s = 1'b0; rw_n_s = 1'b1; din_n_s = 8'h00;       end
        RXRD: begin rs_n_s = 1'b1; rw_n_s = 1'b1; din_n_s = 8'h00;       end
        TXWR: begin rs_n_s = 1'b1; rw_n_s = 1'b0; din_n_s = tx_byte_n_s; end
        default: begin rs_n_s = 1'b0; rw_n_s = 1'b1; din_n_s = 8'h00;    end
      endcase
    end else begin
      din_n_s = 8'h00;
    end
  end

  // State registers, captured status and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= MRST;
      phase_r    <= 2'd0;
      gap_r      <= 8'd0;
      started_r  <= 1'b0;
      pend_r     <= 1'b0;
      ptr_r      <= 1'b0;
      tx_byte_r  <= 8'h00;
      rdrf_r     <= 1'b0;
      tdre_r     <= 1'b0;
      err_r      <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_err     <= 1'b0;
      init_done  <= 1'b0;
      acia_sel   <= 1'b0;
      acia_e     <= 1'b0;
      acia_rs    <= 1'b0;
      acia_rw    <= 1'b1;
      acia_din   <= 8'h00;
    end else begin
      state_r   <= state_n_s;
      phase_r   <= phase_n_s;
      gap_r     <= gap_n_s;
      started_r <= 1'b1;
      pend_r    <= start_mrst_s ? 1'b0 : pend_s;
      ptr_r     <= ptr_n_s;
      tx_byte_r <= tx_byte_n_s;
      if ((state_r == POLL) && (phase_r == 2'd2)) begin
        rdrf_r <= acia_dout[0];
        tdre_r <= acia_dout[1];
        err_r  <= acia_dout[4] | acia_dout[5];
      end
      req0_ready <= (state_r == POLL) && (state_n_s == TXWR) && !grant1_s;
      req1_ready <= (state_r == POLL) && (state_n_s == TXWR) && grant1_s;
      rx_valid   <= (state_r == RXRD) && (phase_r == 2'd2) && !pend_s;
      if ((state_r == RXRD) && (phase_r == 2'd2) && !pend_s) begin
        rx_data <= acia_dout;
        rx_err  <= err_r;
      end
      if (reinit) begin
        init_done <= 1'b0;
      end else if ((state_r == CFG) && (phase_r == 2'd3) && !pend_s) begin
        init_done <= 1'b1;
      end
      acia_sel <= sel_n_s;
      acia_e   <= e_n_s;
      acia_rs  <= rs_n_s;
      acia_rw  <= rw_n_s;
      acia_din <= din_n_s;
    end
  end

endmodule

// File: tb/tb_acia_sequencer.sv
// Bench for acia_sequencer: an ACIA register model answers reads, and a
// transaction-level model predicts each bus access, ready pulse and rx delivery.
module tb_acia_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reinit = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rx_valid, rx_err, init_done;
  logic [7:0] rx_data;
  logic       acia_e, acia_sel, acia_rs, acia_rw;
  logic [7:0] acia_din, acia_dout;
  logic       acia_irq = 1'b0;

  logic [7:0] status_byte = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  assign acia_dout = acia_rs ? rx_byte : status_byte;

  int n_tests = 0, n_fail = 0;
  int mon_r0 = 0, mon_r1 = 0, mon_rxv = 0;
  int exp_r0 = 0, exp_r1 = 0, exp_rxv = 0;
  logic ptr_m = 1'b0;
  logic reinit_at_a1 = 1'b0;

  logic       acc_rs, acc_rw, acc_ok, acc_r0, acc_r1, acc_rxv, acc_rxe, acc_init, acc_init_a3;
  logic [7:0] acc_din, acc_rxd;
  int         acc_idle;

  always #5 clk = ~clk;

  acia_sequencer dut (
    .clk(clk), .reset(reset), .reinit(reinit),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .init_done(init_done),
    .acia_e(acia_e), .acia_sel(acia_sel), .acia_rs(acia_rs), .acia_rw(acia_rw),
    .acia_din(acia_din), .acia_dout(acia_dout), .acia_irq(acia_irq)
  );

  // Count every handshake pulse so stray ones show up in the final totals.
  always @(negedge clk) begin
    if (req0_ready === 1'b1) mon_r0 <= mon_r0 + 1;
    if (req1_ready === 1'b1) mon_r1 <= mon_r1 + 1;
    if (rx_valid === 1'b1)   mon_rxv <= mon_rxv + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait for the next access and record its pins and handshakes over A0..A3.
  task automatic get_access();
    int idle;
    idle = 0;
    acc_ok = 1'b1;
    acc_init = 1'b0;
    @(negedge clk);
    while (acia_sel !== 1'b1 && idle < 300) begin
      if (acia_e !== 1'b0 || acia_rw !== 1'b1 || acia_rs !== 1'b0 || acia_din !== 8'h00) acc_ok = 1'b0;
      idle++;
      @(negedge clk);
    end
    acc_idle = idle;
    if (acia_sel !== 1'b1) begin
      check_eq("access_timeout", 32'd0, 32'd1);
      acc_ok = 1'b0;
      return;
    end
    acc_rs = acia_rs; acc_rw = acia_rw; acc_din = acia_din;
    acc_r0 = req0_ready; acc_r1 = req1_ready;
    if (acia_e !== 1'b0) acc_ok = 1'b0;
    acc_init = acc_init | init_done;
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      if (p == 1 && reinit_at_a1 && acc_rs && !acc_rw) reinit = 1'b1;
      if (p == 2) reinit = 1'b0;
      if (acia_sel !== 1'b1 || acia_e !== 1'b1 || acia_rs !== acc_rs ||
          acia_rw !== acc_rw || acia_din !== acc_din) acc_ok = 1'b0;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rx_valid !== 1'b0) acc_ok = 1'b0;
      acc_init = acc_init | init_done;
    end
    @(negedge clk);
    if (acia_sel !== 1'b0 || acia_e !== 1'b0) acc_ok = 1'b0;
    acc_rxv = rx_valid; acc_rxd = rx_data; acc_rxe = rx_err;
    acc_init_a3 = init_done;
    acc_init = acc_init | init_done;
  endtask

  task automatic expect_init(input int first_idle);
    get_access();
    check_eq("mrst_rs", acc_rs, 1'b0);
    check_eq("mrst_rw", acc_rw, 1'b0);
    check_eq("mrst_din", acc_din, 8'h03);
    check_eq("mrst_gap", acc_idle, first_idle);
    check_eq("mrst_init_low", acc_init, 1'b0);
    check_eq("mrst_shape", acc_ok, 1'b1);
    get_access();
    check_eq("cfg_rs", acc_rs, 1'b0);
    check_eq("cfg_rw", acc_rw, 1'b0);
    check_eq("cfg_din", acc_din, 8'h96);
    check_eq("cfg_gap", acc_idle, 0);
    check_eq("cfg_init_low", acc_init, 1'b0);
    check_eq("cfg_shape", acc_ok, 1'b1);
    @(negedge clk);
    check_eq("init_done_up", init_done, 1'b1);
  endtask

  // One poll and whatever access the status and requesters call for.
  task automatic poll_round(input logic [7:0] st, input int exp_idle);
    int g;
    status_byte = st;
    get_access();
    check_eq("poll_rs", acc_rs, 1'b0);
    check_eq("poll_rw", acc_rw, 1'b1);
    check_eq("poll_gap", acc_idle, exp_idle);
    check_eq("poll_shape", acc_ok, 1'b1);
    check_eq("poll_no_pulse", {acc_r0, acc_r1, acc_rxv}, 3'b000);
    if (st[0]) begin
      get_access();
      check_eq("rx_rs", acc_rs, 1'b1);
      check_eq("rx_rw", acc_rw, 1'b1);
      check_eq("rx_gap", acc_idle, 0);
      check_eq("rx_valid", acc_rxv, 1'b1);
      check_eq("rx_data", acc_rxd, rx_byte);
      check_eq("rx_err", acc_rxe, st[4] | st[5]);
      check_eq("rx_no_ready", {acc_r1, acc_r0}, 2'b00);
      check_eq("rx_shape", acc_ok, 1'b1);
      exp_rxv++;
    end else if (st[1] && (req0_valid || req1_valid)) begin
      if (ptr_m) g = req1_valid ? 1 : 0;
      else       g = req0_valid ? 0 : 1;
      ptr_m = (g == 0);
      get_access();
      check_eq("tx_rs", acc_rs, 1'b1);
      check_eq("tx_rw", acc_rw, 1'b0);
      check_eq("tx_gap", acc_idle, 0);
      check_eq("tx_din", acc_din, (g == 1) ? req1_data : req0_data);
      check_eq("tx_ready", {acc_r1, acc_r0}, (g == 1) ? 2'b10 : 2'b01);
      check_eq("tx_shape", acc_ok, 1'b1);
      if (g == 1) begin exp_r1++; req1_valid = 1'b0; end
      else        begin exp_r0++; req0_valid = 1'b0; end
    end
  endtask

  logic [7:0] t_st [7] = '{8'h01, 8'h21, 8'h02, 8'h02, 8'h02, 8'h03, 8'h02};
  logic       t_v0 [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] t_d0 [7] = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h44, 8'h44};
  logic       t_v1 [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] t_d1 [7] = '{8'h00, 8'h00, 8'h22, 8'h22, 8'h22, 8'h00, 8'h00};
  logic [7:0] t_rx [7] = '{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h6B, 8'h00};

  initial begin
    logic [7:0] st;
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_sel", acia_sel, 1'b0);
    check_eq("rst_e", acia_e, 1'b0);
    check_eq("rst_rw", acia_rw, 1'b1);
    check_eq("rst_rs_din", {acia_rs, acia_din}, 9'h000);
    check_eq("rst_flags", {init_done, rx_valid, rx_err, req0_ready, req1_ready}, 5'b00000);
    check_eq("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    expect_init(0);

    for (int i = 0; i < 7; i++) begin
      req0_valid = t_v0[i]; req0_data = t_d0[i];
      req1_valid = t_v1[i]; req1_data = t_d1[i];
      rx_byte = t_rx[i];
      poll_round(t_st[i], (i == 0) ? 15 : 16);
    end

    for (int i = 0; i < 50; i++) begin
      if (req0_valid) begin
        if ($urandom_range(0, 3) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end
      if (req1_valid) begin
        if ($urandom_range(0, 3) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_data = 8'($urandom);
      end
      st = 8'($urandom);
      if ($urandom_range(0, 2) != 0) st[0] = 1'b0;
      rx_byte = 8'($urandom);
      poll_round(st, 16);
    end

    // reinit in A1 of a tx write
    req0_valid = 1'b1; req0_data = 8'h77; req1_valid = 1'b0;
    reinit_at_a1 = 1'b1;
    poll_round(8'h02, 16);
    reinit_at_a1 = 1'b0;
    check_eq("reinit_init_low", acc_init_a3, 1'b0);
    expect_init(0);
    poll_round(8'h00, 15);

    // reset in A1 of a poll
    req0_valid = 1'b1; req0_data = 8'hA1; req1_valid = 1'b1; req1_data = 8'hB2;
    status_byte = 8'h02;
    n = 0;
    @(negedge clk);
    while (acia_sel !== 1'b1 && n < 300) begin n++; @(negedge clk); end
    check_eq("rst_wait_access", acia_sel, 1'b1);
    @(negedge clk);
    check_eq("rst_a1_e", acia_e, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_abort_e_sel", {acia_e, acia_sel}, 2'b00);
    check_eq("rst_abort_init", init_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 1'b0;
    expect_init(0);
    poll_round(8'h02, 15);
    req0_valid = 1'b1;
    poll_round(8'h02, 16);

    repeat (3) @(negedge clk);
    check_eq("ready0_count", mon_r0, exp_r0);
    check_eq("ready1_count", mon_r1, exp_r1);
    check_eq("rx_valid_count", mon_rxv, exp_rxv);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
